// File: rtl/grad_eval_arbiter.sv
// -----------------------------------------------------------------------------
// grad_eval_arbiter
//
// Round-robin arbiter and sequencer that shares one function/gradient
// evaluator between NUM_REQ optimiser lanes. A winning lane's Q24.8 point is
// driven to the evaluator. When the evaluator completes, its value and step
// size are returned to that lane. The evaluator is then flushed through a
// one-cycle pulse on its reset, so nothing carries over to the next lane.
//
// Sequence per service: IDLE -> LAUNCH -> WAIT -> RESP -> FLUSH -> IDLE.
// Every output is registered.
//
// Optional feature (macro EVAL_TIMEOUT_EN):
//   Adds a WAIT-state watchdog and a resp_err output. After TIMEOUT_CYCLES
//   WAIT cycles without eval_done, the block returns a saturated value with
//   resp_err=1. Without the macro, WAIT waits indefinitely.
//
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   req          : level request per lane, held until that lane's resp_valid
//   req_x        : flat per-lane points, lane i at [32*i+31:32*i]
//   grant        : one-hot lane being served, 0 when idle
//   busy         : high whenever the sequencer is not IDLE
//   resp_valid   : one-cycle result pulse
//   resp_id      : lane the result belongs to
//   resp_value   : evaluator function value (signed 64)
//   resp_x_diff  : evaluator step size (signed 32)
//   resp_err     : watchdog expiry flag (EVAL_TIMEOUT_EN only)
//   eval_rst_n   : active-low reset to the evaluator
//   eval_start   : level start to the evaluator
//   eval_x       : point driven to the evaluator
//   eval_done    : evaluator completion flag
//   eval_value   : evaluator value output
//   eval_x_diff  : evaluator step output
// -----------------------------------------------------------------------------
module grad_eval_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [32*NUM_REQ-1:0]    req_x,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic signed [63:0]       resp_value,
  output logic signed [31:0]       resp_x_diff,
`ifdef EVAL_TIMEOUT_EN
  output logic                     resp_err,
`endif
  output logic                     eval_rst_n,
  output logic                     eval_start,
  output logic [31:0]              eval_x,
  input  logic                     eval_done,
  input  logic [63:0]              eval_value,
  input  logic [31:0]              eval_x_diff
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  localparam logic [NUM_REQ-1:0] LANE0_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]    LAST_LANE = ID_W'(NUM_REQ - 1);

  state_t                state_r, state_s;
  logic [ID_W-1:0]       last_id_r, last_id_s;
  logic [NUM_REQ-1:0]    grant_r, grant_s;
  logic                  busy_r, busy_s;
  logic                  resp_valid_r, resp_valid_s;
  logic [ID_W-1:0]       resp_id_r, resp_id_s;
  logic signed [63:0]    resp_value_r, resp_value_s;
  logic signed [31:0]    resp_x_diff_r, resp_x_diff_s;
  logic                  eval_rst_n_r, eval_rst_n_s;
  logic                  eval_start_r, eval_start_s;
  logic [31:0]           eval_x_r, eval_x_s;

  logic                  any_req_s;
  logic                  hi_found_s;
  logic [ID_W-1:0]       hi_id_s, lo_id_s, win_id_s;
  logic [31:0]           lane_x_s [NUM_REQ];

`ifdef EVAL_TIMEOUT_EN
  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1'b1);
  localparam logic signed [63:0] VALUE_SAT = 64'sh7FFF_FFFF_FFFF_FFFF;

  logic [TO_W-1:0]       wait_cnt_r, wait_cnt_s;
  logic                  resp_err_r, resp_err_s;
`else
  // The watchdog limit has no effect when the watchdog is not built.
  logic                  unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYCLES > 0);
`endif

  // Round-robin pick: lowest requesting lane above last_id, else lowest overall.
  always_comb begin
    any_req_s  = 1'b0;
    hi_found_s = 1'b0;
    hi_id_s    = {ID_W{1'b0}};
    lo_id_s    = {ID_W{1'b0}};
    // Scanning downward leaves the lowest matching index in each result.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      lane_x_s[i] = req_x[32*i +: 32];
      if (req[i]) begin
        any_req_s = 1'b1;
        lo_id_s   = ID_W'(i);
        if (ID_W'(i) > last_id_r) begin
          hi_found_s = 1'b1;
          hi_id_s    = ID_W'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        any_req_s = any_req_s;
      end
    end
    win_id_s = hi_found_s ? hi_id_s : lo_id_s;
  end

  // Next-state and next-output logic for the service sequencer.
  always_comb begin
    state_s       = state_r;
    last_id_s     = last_id_r;
    grant_s       = grant_r;
    busy_s        = busy_r;
    resp_valid_s  = resp_valid_r;
    resp_id_s     = resp_id_r;
    resp_value_s  = resp_value_r;
    resp_x_diff_s = resp_x_diff_r;
    eval_rst_n_s  = eval_rst_n_r;
    eval_start_s  = eval_start_r;
    eval_x_s      = eval_x_r;
`ifdef EVAL_TIMEOUT_EN
    wait_cnt_s    = wait_cnt_r;
    resp_err_s    = resp_err_r;
`endif
    case (state_r)
      IDLE: begin
        eval_rst_n_s = 1'b1;
        if (any_req_s) begin
          last_id_s = win_id_s;
          resp_id_s = win_id_s;
          grant_s   = LANE0_HOT << win_id_s;
          eval_x_s  = lane_x_s[win_id_s];
          busy_s    = 1'b1;
          state_s   = LAUNCH;
        end else begin
          state_s   = IDLE;
        end
      end
      LAUNCH: begin
        eval_start_s = 1'b1;
`ifdef EVAL_TIMEOUT_EN
        wait_cnt_s   = {TO_W{1'b0}};
`endif
        state_s      = WAIT;
      end
      WAIT: begin
        if (eval_done) begin
          resp_value_s  = eval_value;
          resp_x_diff_s = eval_x_diff;
          eval_start_s  = 1'b0;
          resp_valid_s  = 1'b1;
`ifdef EVAL_TIMEOUT_EN
          resp_err_s    = 1'b0;
`endif
          state_s       = RESP;
        end
`ifdef EVAL_TIMEOUT_EN
        else if (wait_cnt_r == TO_LAST) begin
          // Evaluator never answered: return a saturated value and flag it.
          resp_value_s  = VALUE_SAT;
          resp_x_diff_s = 32'sd0;
          eval_start_s  = 1'b0;
          resp_valid_s  = 1'b1;
          resp_err_s    = 1'b1;
          state_s       = RESP;
        end else begin
          wait_cnt_s    = wait_cnt_r + TO_ONE;
          state_s       = WAIT;
        end
`else
        else begin
          state_s       = WAIT;
        end
`endif
      end
      RESP: begin
        resp_valid_s = 1'b0;
        grant_s      = {NUM_REQ{1'b0}};
        eval_rst_n_s = 1'b0;
        state_s      = FLUSH;
      end
      FLUSH: begin
        eval_rst_n_s = 1'b1;
        busy_s       = 1'b0;
        state_s      = IDLE;
      end
      default: begin
        grant_s      = {NUM_REQ{1'b0}};
        busy_s       = 1'b0;
        resp_valid_s = 1'b0;
        eval_start_s = 1'b0;
        eval_rst_n_s = 1'b0;
        state_s      = IDLE;
      end
    endcase
  end

  // State and output registers; an asynchronous reset aborts any service.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      last_id_r     <= LAST_LANE;
      grant_r       <= {NUM_REQ{1'b0}};
      busy_r        <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_id_r     <= {ID_W{1'b0}};
      resp_value_r  <= 64'sd0;
      resp_x_diff_r <= 32'sd0;
      eval_rst_n_r  <= 1'b0;
      eval_start_r  <= 1'b0;
      eval_x_r      <= 32'd0;
`ifdef EVAL_TIMEOUT_EN
      wait_cnt_r    <= {TO_W{1'b0}};
      resp_err_r    <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      last_id_r     <= last_id_s;
      grant_r       <= grant_s;
      busy_r        <= busy_s;
      resp_valid_r  <= resp_valid_s;
      resp_id_r     <= resp_id_s;
      resp_value_r  <= resp_value_s;
      resp_x_diff_r <= resp_x_diff_s;
      eval_rst_n_r  <= eval_rst_n_s;
      eval_start_r  <= eval_start_s;
      eval_x_r      <= eval_x_s;
`ifdef EVAL_TIMEOUT_EN
      wait_cnt_r    <= wait_cnt_s;
      resp_err_r    <= resp_err_s;
`endif
    end
  end

  assign grant       = grant_r;
  assign busy        = busy_r;
  assign resp_valid  = resp_valid_r;
  assign resp_id     = resp_id_r;
  assign resp_value  = resp_value_r;
  assign resp_x_diff = resp_x_diff_r;
  assign eval_rst_n  = eval_rst_n_r;
  assign eval_start  = eval_start_r;
  assign eval_x      = eval_x_r;
`ifdef EVAL_TIMEOUT_EN
  assign resp_err    = resp_err_r;
`endif

endmodule

// File: tb/tb_grad_eval_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grad_eval_arbiter
//
// Directed bench for grad_eval_arbiter with a behavioural evaluator.
// The evaluator raises eval_done 5 cycles after eval_start rises and holds it
// until eval_rst_n is low. It returns value = {32'h0,x}+1 and step = x>>>1.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_grad_eval_arbiter;

  localparam int EV_L = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_x;
  logic [3:0]   grant;
  logic         busy;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic signed [63:0] resp_value;
  logic signed [31:0] resp_x_diff;
  logic         eval_rst_n;
  logic         eval_start;
  logic [31:0]  eval_x;
  logic         eval_done = 1'b0;
  logic [63:0]  eval_value;
  logic [31:0]  eval_x_diff;
  logic         ev_hang = 1'b0;
  int           ev_cnt = 0;
`ifdef EVAL_TIMEOUT_EN
  logic         resp_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic [1:0]  b_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [63:0] b_val [4] = '{64'h101, 64'h301, 64'h501, 64'h701};

`ifdef EVAL_TIMEOUT_EN
  grad_eval_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
`else
  grad_eval_arbiter #(.NUM_REQ(4)) dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_x       (req_x),
    .grant       (grant),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_value  (resp_value),
    .resp_x_diff (resp_x_diff),
`ifdef EVAL_TIMEOUT_EN
    .resp_err    (resp_err),
`endif
    .eval_rst_n  (eval_rst_n),
    .eval_start  (eval_start),
    .eval_x      (eval_x),
    .eval_done   (eval_done),
    .eval_value  (eval_value),
    .eval_x_diff (eval_x_diff)
  );

  always #5 clk = ~clk;

  // Behavioural evaluator: done after EV_L cycles of start, cleared by its reset.
  always @(posedge clk or negedge eval_rst_n) begin
    if (!eval_rst_n) begin
      ev_cnt    <= 0;
      eval_done <= 1'b0;
    end else if (eval_start && !eval_done && !ev_hang) begin
      if (ev_cnt == EV_L - 1) eval_done <= 1'b1;
      ev_cnt <= ev_cnt + 1;
    end
  end

  assign eval_value  = {32'h0, eval_x} + 64'h1;
  assign eval_x_diff = $signed(eval_x) >>> 1;

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_x(input int lane, input logic [31:0] v);
    req_x[32*lane +: 32] = v;
  endtask

  // Advance until resp_valid is seen, bounded; returns cycles advanced.
  task automatic wait_resp(output int c);
    c = 0;
    while (resp_valid !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    req_x = 128'h0;

    // Reset state.
    @(negedge clk);
    chk("rst_grant", grant, 64'h0);
    chk("rst_busy", busy, 64'h0);
    chk("rst_resp_valid", resp_valid, 64'h0);
    chk("rst_resp_id", resp_id, 64'h0);
    chk("rst_resp_value", resp_value, 64'h0);
    chk("rst_resp_x_diff", $unsigned(resp_x_diff), 64'h0);
    chk("rst_eval_start", eval_start, 64'h0);
    chk("rst_eval_x", eval_x, 64'h0);
    chk("rst_eval_rst_n", eval_rst_n, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_eval_rst_n", eval_rst_n, 64'h1);

    // Single lane 0, x=0x200: resp_valid 8 cycles after the sampling edge.
    set_x(0, 32'h0000_0200);
    req = 4'b0001;
    tick();
    chk("a_grant", grant, 64'h1);
    chk("a_busy", busy, 64'h1);
    chk("a_eval_x", eval_x, 64'h200);
    wait_resp(cyc);
    chk("a_latency", cyc + 1, 64'd8);
    chk("a_resp_valid", resp_valid, 64'h1);
    chk("a_resp_id", resp_id, 64'h0);
    chk("a_resp_value", resp_value, 64'h201);
    chk("a_resp_x_diff", $unsigned(resp_x_diff), 64'h100);
    chk("a_eval_start_clr", eval_start, 64'h0);
    req = 4'b0000;
    tick();
    chk("a_flush_valid", resp_valid, 64'h0);
    chk("a_flush_eval_rst_n", eval_rst_n, 64'h0);
    chk("a_flush_grant", grant, 64'h0);
    tick();
    chk("a_idle_eval_rst_n", eval_rst_n, 64'h1);
    chk("a_idle_busy", busy, 64'h0);

    // Lane 1 alone, so lane 1 is the last served.
    set_x(1, 32'h0000_0080);
    req = 4'b0010;
    wait_resp(cyc);
    chk("l1_resp_id", resp_id, 64'h1);
    chk("l1_resp_value", resp_value, 64'h81);
    req = 4'b0000;
    tick();
    tick();

    // req=1010 after lane 1: lane 3 first, then lane 1.
    set_x(3, 32'h0000_1000);
    req = 4'b1010;
    wait_resp(cyc);
    chk("rr_first_id", resp_id, 64'h3);
    chk("rr_first_value", resp_value, 64'h1001);
    chk("rr_first_x_diff", $unsigned(resp_x_diff), 64'h800);
    req[3] = 1'b0;
    tick();
    wait_resp(cyc);
    chk("rr_second_valid", resp_valid, 64'h1);
    chk("rr_second_id", resp_id, 64'h1);
    chk("rr_second_value", resp_value, 64'h81);
    req = 4'b0000;
    tick();
    tick();

    // Negative point on lane 2.
    set_x(2, 32'hFFFF_FF00);
    req = 4'b0100;
    wait_resp(cyc);
    chk("neg_resp_id", resp_id, 64'h2);
    chk("neg_resp_value", resp_value, 64'h0000_0000_FFFF_FF01);
    chk("neg_resp_x_diff", $unsigned(resp_x_diff), 64'hFFFF_FF80);
    req = 4'b0000;
    tick();
    tick();

    // Reset asserted during WAIT aborts at once.
    req = 4'b0100;
    tick();
    tick();
    chk("mid_eval_start", eval_start, 64'h1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 64'h0);
    chk("mid_rst_busy", busy, 64'h0);
    chk("mid_rst_eval_start", eval_start, 64'h0);
    chk("mid_rst_eval_x", eval_x, 64'h0);
    chk("mid_rst_eval_rst_n", eval_rst_n, 64'h0);
    chk("mid_rst_resp_value", resp_value, 64'h0);
    chk("mid_rst_resp_x_diff", $unsigned(resp_x_diff), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_valid", resp_valid, 64'h0);
    end

    // All four lanes requesting from reset: order 0,1,2,3,0 with 9 idle
    // cycles between consecutive pulses.
    set_x(0, 32'h0000_0100);
    set_x(1, 32'h0000_0300);
    set_x(2, 32'h0000_0500);
    set_x(3, 32'h0000_0700);
    req   = 4'b1111;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      wait_resp(cyc);
      if (i > 0) chk("all_gap", cyc, 64'd9);
      chk("all_valid", resp_valid, 64'h1);
      chk("all_resp_id", resp_id, b_id[i]);
      chk("all_resp_value", resp_value, b_val[b_id[i]]);
    end
    req = 4'b0000;
    tick();
    tick();

`ifdef EVAL_TIMEOUT_EN
    // Evaluator never finishes: saturated error response after 16 WAIT cycles.
    ev_hang = 1'b1;
    req = 4'b0110;
    tick();
    chk("to_grant", grant, 64'h2);
    wait_resp(cyc);
    chk("to_latency", cyc, 64'd17);
    chk("to_resp_id", resp_id, 64'h1);
    chk("to_resp_err", resp_err, 64'h1);
    chk("to_resp_value", resp_value, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("to_resp_x_diff", $unsigned(resp_x_diff), 64'h0);
    req[1]  = 1'b0;
    ev_hang = 1'b0;
    tick();
    wait_resp(cyc);
    chk("to_next_id", resp_id, 64'h2);
    chk("to_next_err", resp_err, 64'h0);
    chk("to_next_value", resp_value, 64'h501);
    req = 4'b0000;
    tick();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
